// File: rtl/vend_session_arbiter_if.sv
// Coin-acceptor side and actuator side signals of the shared vending session arbiter.
// The arbiter takes the slave modport; front-end models and actuators take the master modport.
interface vend_session_arbiter_if #(
    parameter int unsigned NREQ = 4
) ();
    localparam int unsigned OW = $clog2(NREQ);

    logic [3*NREQ-1:0] coin;
    logic [NREQ-1:0]   cancel;
    logic              busy;
    logic [OW-1:0]     owner;
    logic [5:0]        credit;
    logic [NREQ-1:0]   reject;
    logic              vend;
    logic              refund;
    logic              chg_pulse;
    logic              chg_done;

    modport master (
        output coin, cancel,
        input  busy, owner, credit, reject, vend, refund, chg_pulse, chg_done
    );

    modport slave (
        input  coin, cancel,
        output busy, owner, credit, reject, vend, refund, chg_pulse, chg_done
    );
endinterface

// File: rtl/vend_session_arbiter.sv
// Round-robin grant of one vending session among NREQ coin acceptors, with credit
// accumulation, vend pulse and 5-rupee change/refund dispensing. All outputs are registered.
module vend_session_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned PRICE   = 25,
    parameter int unsigned TIMEOUT = 15
) (
    input logic                 clock,
    input logic                 reset,
    vend_session_arbiter_if.slave bus
);
    localparam int unsigned OW     = $clog2(NREQ);
    localparam int unsigned TW     = $clog2(TIMEOUT + 1);
    localparam logic [5:0]  PRICE6 = 6'(PRICE);

    typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [5:0]      credit_q, credit_d;
    logic [2:0]      chg_cnt_q, chg_cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [NREQ-1:0] reject_q, reject_d;
    logic            busy_q, busy_d;
    logic            vend_q, vend_d;
    logic            refund_q, refund_d;
    logic            pulse_q, pulse_d;
    logic            done_q, done_d;

    logic [NREQ-1:0] present, valid;
    logic            found;
    logic [OW-1:0]   win;
    int unsigned     idx;
    logic [5:0]      win_value, own_value, sum;
    logic [2:0]      own_code;
    logic            own_cancel, own_valid, own_present, go_refund;

    function automatic logic [5:0] coin_value(input logic [2:0] code);
        case (code)
            3'b001:  return 6'd5;
            3'b010:  return 6'd10;
            3'b011:  return 6'd15;
            3'b101:  return 6'd20;
            default: return 6'd0;
        endcase
    endfunction

    always_comb begin
        present = '0;
        valid   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            present[i] = bus.coin[3*i +: 3] != 3'b000;
            valid[i]   = coin_value(bus.coin[3*i +: 3]) != 6'd0;
        end
    end

    // Round-robin search starting one past the last owner.
    always_comb begin
        found = 1'b0;
        win   = owner_q;
        idx   = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(owner_q) + i) % NREQ;
            if (!found && valid[idx]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
    end

    assign win_value   = coin_value(bus.coin[3*win +: 3]);
    assign own_code    = bus.coin[3*owner_q +: 3];
    assign own_value   = coin_value(own_code);
    assign own_present = own_code != 3'b000;
    assign own_valid   = own_value != 6'd0;
    assign own_cancel  = bus.cancel[owner_q];
    assign sum         = credit_q + own_value;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        credit_d  = credit_q;
        chg_cnt_d = chg_cnt_q;
        tmo_d     = tmo_q;
        reject_d  = present;
        vend_d    = 1'b0;
        refund_d  = 1'b0;
        pulse_d   = 1'b0;
        done_d    = 1'b0;
        go_refund = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    reject_d[win] = 1'b0;
                    owner_d       = win;
                    credit_d      = win_value;
                    tmo_d         = '0;
                    if (win_value >= PRICE6) begin
                        state_d   = StVend;
                        vend_d    = 1'b1;
                        chg_cnt_d = 3'((win_value - PRICE6) / 6'd5);
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (own_cancel) begin
                    go_refund = 1'b1;
                end else if (own_valid) begin
                    reject_d[owner_q] = 1'b0;
                    credit_d          = sum;
                    tmo_d             = '0;
                    if (sum >= PRICE6) begin
                        state_d   = StVend;
                        vend_d    = 1'b1;
                        chg_cnt_d = 3'((sum - PRICE6) / 6'd5);
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    go_refund = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                // Refund starts dispensing in the very next cycle, so the first pulse is here.
                if (go_refund) begin
                    state_d   = StChange;
                    refund_d  = 1'b1;
                    pulse_d   = 1'b1;
                    chg_cnt_d = 3'(credit_q / 6'd5) - 3'd1;
                end
            end
            StVend: begin
                if (chg_cnt_q != 3'd0) begin
                    state_d   = StChange;
                    pulse_d   = 1'b1;
                    chg_cnt_d = chg_cnt_q - 3'd1;
                end else begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    credit_d = '0;
                end
            end
            StChange: begin
                if (chg_cnt_q != 3'd0) begin
                    pulse_d   = 1'b1;
                    chg_cnt_d = chg_cnt_q - 3'd1;
                end else begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    credit_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // The session is still reported busy during its closing chg_done cycle.
        busy_d = (state_d != StIdle) || done_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            owner_q   <= OW'(NREQ - 1);
            credit_q  <= '0;
            chg_cnt_q <= '0;
            tmo_q     <= '0;
            reject_q  <= '0;
            busy_q    <= 1'b0;
            vend_q    <= 1'b0;
            refund_q  <= 1'b0;
            pulse_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            credit_q  <= credit_d;
            chg_cnt_q <= chg_cnt_d;
            tmo_q     <= tmo_d;
            reject_q  <= reject_d;
            busy_q    <= busy_d;
            vend_q    <= vend_d;
            refund_q  <= refund_d;
            pulse_q   <= pulse_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.credit    = credit_q;
    assign bus.reject    = reject_q;
    assign bus.vend      = vend_q;
    assign bus.refund    = refund_q;
    assign bus.chg_pulse = pulse_q;
    assign bus.chg_done  = done_q;
endmodule
